// File: rtl/serial_seq_tx_pkg.sv
// Shared types and defaults for the serial sequence transmitter.
// The state encoding is fixed here so the transmitter and its consumers agree on it.
package serial_seq_tx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_SHIFT = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_SHIFT = ENC_SHIFT,
    ST_DONE  = ENC_DONE
  } state_e;

endpackage

// File: rtl/serial_seq_tx_if.sv
// Control/stream bundle between the controlling logic (master) and the transmitter (slave).
// The serial x/x_valid outputs also feed the downstream detector.
interface serial_seq_tx_if #(
  parameter int WIDTH = serial_seq_tx_pkg::DEF_WIDTH,
  parameter int REP_W = serial_seq_tx_pkg::DEF_REP_W
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [REP_W-1:0] rep_cnt;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, data_in, rep_cnt,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, data_in, rep_cnt,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/serial_seq_tx_shifter.sv
// Pattern shift register plus bit counter; the head bit is a register bit,
// and clearing on the final bit keeps the head at 0 whenever nothing is being sent.
module serial_seq_tx_shifter
  import serial_seq_tx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             head_o,
  output logic             last_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_shifted;
  logic [CW-1:0]    bit_cnt_q;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
      assign head_o     = sr_q[WIDTH-1];
    end else begin : g_lsb
      assign sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
      assign head_o     = sr_q[0];
    end
  endgenerate

  assign last_o = (bit_cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else if (clear_i) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else if (load_i) begin
      sr_q      <= load_data_i;
      bit_cnt_q <= '0;
    end else if (shift_i) begin
      sr_q      <= sr_shifted;
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_seq_tx.sv
// Serial pattern transmitter: loads a pattern, shifts it out one bit per clock
// for rep_cnt+1 back-to-back passes, then pulses done for one cycle.
module serial_seq_tx
  import serial_seq_tx_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int REP_W     = DEF_REP_W,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_seq_tx_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] pattern_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] pass_q;
  logic [REP_W-1:0] pass_d;
  logic             x_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             sh_load;
  logic             sh_shift;
  logic             sh_clear;
  logic             sh_last;
  logic             sh_head;
  logic [WIDTH-1:0] sh_data;
  logic             final_pass;

  // pass_q never passes rep_q, so an all-ones repeat count gives 2^REP_W passes without wrapping.
  assign final_pass = (pass_q == rep_q);
  assign pass_d     = pass_q + 1'b1;

  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_clear = 1'b0;
    sh_data  = pattern_q;
    case (state_q)
      ST_IDLE: begin
        sh_load = bus.start;
        sh_data = bus.data_in;
      end
      ST_SHIFT: begin
        sh_shift = !sh_last;
        sh_load  = sh_last && !final_pass;
        sh_clear = sh_last && final_pass;
      end
      default: ;
    endcase
  end

  serial_seq_tx_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sh_load),
    .shift_i     (sh_shift),
    .clear_i     (sh_clear),
    .load_data_i (sh_data),
    .head_o      (sh_head),
    .last_o      (sh_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      rep_q     <= '0;
      pass_q    <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            pattern_q <= bus.data_in;
            rep_q     <= bus.rep_cnt;
            pass_q    <= '0;
            x_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sh_last) begin
            if (final_pass) begin
              x_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= ST_DONE;
            end else begin
              pass_q <= pass_d;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          x_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.x       = sh_head;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Bench for serial_seq_tx: MSB-first and LSB-first instances driven in parallel,
// checked every cycle against a queue-based stream model plus directed vectors.
module tb_serial_seq_tx;

  localparam int W  = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  din = '0;
  logic [RW-1:0] rep = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  serial_seq_tx_if #(.WIDTH(W), .REP_W(RW)) if_m ();
  serial_seq_tx_if #(.WIDTH(W), .REP_W(RW)) if_l ();

  assign if_m.start   = start;
  assign if_m.data_in = din;
  assign if_m.rep_cnt = rep;
  assign if_l.start   = start;
  assign if_l.data_in = din;
  assign if_l.rep_cnt = rep;

  serial_seq_tx #(.WIDTH(W), .REP_W(RW), .MSB_FIRST(1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (if_m.slave)
  );

  serial_seq_tx #(.WIDTH(W), .REP_W(RW), .MSB_FIRST(0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if_l.slave)
  );

  // Expected per-cycle outputs {x, x_valid, busy, done}; an empty queue means idle.
  logic [3:0] mq_m[$];
  logic [3:0] mq_l[$];

  function automatic void push_xfer(input logic [W-1:0] d, input logic [RW-1:0] r);
    for (int p = 0; p <= int'(r); p++) begin
      for (int k = 0; k < W; k++) begin
        mq_m.push_back({d[W-1-k], 3'b110});
        mq_l.push_back({d[k], 3'b110});
      end
    end
    mq_m.push_back(4'b0001);
    mq_l.push_back(4'b0001);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq_m.delete();
      mq_l.delete();
    end else if (mq_m.size() > 0) begin
      void'(mq_m.pop_front());
      void'(mq_l.pop_front());
    end else if (start) begin
      push_xfer(din, rep);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("stream_msb", {28'd0, if_m.x, if_m.x_valid, if_m.busy, if_m.done},
            {28'd0, (mq_m.size() > 0) ? mq_m[0] : 4'b0000});
      check("stream_lsb", {28'd0, if_l.x, if_l.x_valid, if_l.busy, if_l.done},
            {28'd0, (mq_l.size() > 0) ? mq_l[0] : 4'b0000});
    end
  end

  task automatic check_quiet(input string name);
    check({name, "_msb"}, {28'd0, if_m.x, if_m.x_valid, if_m.busy, if_m.done}, 32'd0);
    check({name, "_lsb"}, {28'd0, if_l.x, if_l.x_valid, if_l.busy, if_l.done}, 32'd0);
  endtask

  // One transfer; captures the first W sent bits of each instance (first-sent bit in the MSB).
  task automatic run_xfer(input logic [W-1:0] d, input logic [RW-1:0] r, input bit poke,
                          output int nbits, output int nbad, output int ndone, output int nbusy,
                          output logic [W-1:0] cap_m, output logic [W-1:0] cap_l);
    nbits = 0; nbad = 0; ndone = 0; nbusy = 0; cap_m = '0; cap_l = '0;
    @(negedge clk);
    start = 1'b1; din = d; rep = r;
    @(negedge clk);
    start = 1'b0; din = W'($urandom); rep = RW'($urandom);
    for (int c = 0; c < 300; c++) begin
      if (if_m.x_valid) begin
        if (if_m.x !== d[W-1-(nbits % W)]) nbad++;
        if (if_l.x !== d[nbits % W]) nbad++;
        if (nbits < W) begin
          cap_m = {cap_m[W-2:0], if_m.x};
          cap_l = {cap_l[W-2:0], if_l.x};
        end
        nbits++;
      end
      if (if_m.busy) nbusy++;
      if (if_m.done) begin
        ndone++;
        break;
      end
      start = (poke && nbits == 3);
      din   = (poke && nbits == 3) ? 8'hFF : din;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0]  d;
    logic [RW-1:0] r;
    bit            poke;
    int            exp_bits;
    logic [W-1:0]  exp_m;
    logic [W-1:0]  exp_l;
  } vec_t;

  vec_t tbl[6];

  int nbits, nbad, ndone, nbusy;
  logic [W-1:0] cap_m, cap_l;
  logic [W-1:0] rd;
  logic [RW-1:0] rr;

  initial begin
    tbl[0] = '{8'b1010_0101, 4'd0,  1'b0, 8,   8'b1010_0101, 8'b1010_0101};
    tbl[1] = '{8'b1100_0001, 4'd2,  1'b0, 24,  8'b1100_0001, 8'b1000_0011};
    tbl[2] = '{8'h00,        4'd0,  1'b1, 8,   8'h00,        8'h00};
    tbl[3] = '{8'h3C,        4'd1,  1'b0, 16,  8'b0011_1100, 8'b0011_1100};
    tbl[4] = '{8'b0000_0110, 4'd0,  1'b0, 8,   8'b0000_0110, 8'b0110_0000};
    tbl[5] = '{8'h5A,        4'd15, 1'b0, 128, 8'b0101_1010, 8'b0101_1010};

    #7;
    check_quiet("reset_hold");
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("idle_no_start");

    foreach (tbl[i]) begin
      run_xfer(tbl[i].d, tbl[i].r, tbl[i].poke, nbits, nbad, ndone, nbusy, cap_m, cap_l);
      $display("vec %0d: data=%h rep=%0d bits=%0d done=%0d", i, tbl[i].d, tbl[i].r, nbits, ndone);
      check($sformatf("vec%0d_bits", i), nbits, tbl[i].exp_bits);
      check($sformatf("vec%0d_busy", i), nbusy, tbl[i].exp_bits);
      check($sformatf("vec%0d_done", i), ndone, 1);
      check($sformatf("vec%0d_bad", i), nbad, 0);
      check($sformatf("vec%0d_seq_msb", i), cap_m, tbl[i].exp_m);
      check($sformatf("vec%0d_seq_lsb", i), cap_l, tbl[i].exp_l);
    end

    // start held through the DONE cycle must only take effect once back in IDLE
    run_xfer(8'h81, 4'd0, 1'b0, nbits, nbad, ndone, nbusy, cap_m, cap_l);
    start = 1'b1; din = 8'h42; rep = 4'd0;
    @(negedge clk);
    check("done_start_ignored", {31'd0, if_m.x_valid}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("idle_start_taken", {31'd0, if_m.x_valid}, 32'd1);
    repeat (10) @(negedge clk);
    $display("back-to-back: start in DONE ignored, accepted from IDLE");

    // asynchronous abort in the middle of a transfer
    @(negedge clk);
    start = 1'b1; din = 8'hA5; rep = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_quiet("async_abort");
    @(negedge clk);
    check_quiet("abort_hold");
    #2 rst = 1'b1;
    @(negedge clk);
    check_quiet("abort_no_done");
    run_xfer(8'h3C, 4'd0, 1'b0, nbits, nbad, ndone, nbusy, cap_m, cap_l);
    $display("post-abort: data=3c bits=%0d done=%0d", nbits, ndone);
    check("post_abort_seq", cap_m, 8'b0011_1100);
    check("post_abort_bits", nbits, 8);

    for (int i = 0; i < 12; i++) begin
      rd = W'($urandom);
      rr = RW'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_xfer(rd, rr, bit'($urandom_range(0, 1)), nbits, nbad, ndone, nbusy, cap_m, cap_l);
      $display("rand %0d: data=%h rep=%0d bits=%0d done=%0d", i, rd, rr, nbits, ndone);
      check($sformatf("rand%0d_bits", i), nbits, W * (int'(rr) + 1));
      check($sformatf("rand%0d_done", i), ndone, 1);
      check($sformatf("rand%0d_bad", i), nbad, 0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
